mem_port_arbiter: RTL and testbench

- Shares the single MMU memory port between two requesters: port 0 (Vicuna vector unit) and port 1 (Ibex instruction/data).
- Each side uses the MMU-style req/rvalid handshake: the requester holds req until its rvalid.
- At most one transaction is outstanding. Arbitration is round-robin, and a timeout terminates hung downstream accesses with an error.
- Sits between the cores and mmu; its downstream port connects directly to mmu's vproc_mem_* port.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one MMU memory port between the vector unit (port 0)
// and Ibex (port 1), one transaction in flight, with a watchdog on hung accesses.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic              p0_we_i,
  input  logic [DATA_W/8-1:0] p0_be_i,
  input  logic [DATA_W-1:0] p0_wdata_i,
  output logic              p0_gnt_o,
  output logic              p0_rvalid_o,
  output logic              p0_err_o,
  output logic [DATA_W-1:0] p0_rdata_o,
  input  logic              p1_req_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic              p1_we_i,
  input  logic [DATA_W/8-1:0] p1_be_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  output logic              p1_gnt_o,
  output logic              p1_rvalid_o,
  output logic              p1_err_o,
  output logic [DATA_W-1:0] p1_rdata_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic              mem_err_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t              state, state_next;
  logic                owner, last_grant;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic                take, pick, cap_en, cap_err;
  logic [DATA_W-1:0]   cap_data;

  // Downstream completion beats the watchdog when both land on the same edge.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    pick       = owner;
    cap_en     = 1'b0;
    cap_err    = 1'b0;
    cap_data   = '0;
    case (state)
      IDLE: begin
        if (p0_req_i && p1_req_i) begin
          take = 1'b1;
          pick = ~last_grant;
        end else if (p0_req_i) begin
          take = 1'b1;
          pick = 1'b0;
        end else if (p1_req_i) begin
          take = 1'b1;
          pick = 1'b1;
        end
        if (take) state_next = ISSUE;
      end
      ISSUE: begin
        if (mem_rvalid_i || mem_err_i) begin
          cap_en     = 1'b1;
          cap_err    = mem_err_i;
          cap_data   = mem_rdata_i;
          state_next = DONE;
        end else if (cnt == CNT_LIMIT) begin
          cap_en     = 1'b1;
          cap_err    = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_next;
      if (take) begin
        owner      <= pick;
        last_grant <= pick;
        addr_q     <= pick ? p1_addr_i  : p0_addr_i;
        we_q       <= pick ? p1_we_i    : p0_we_i;
        be_q       <= pick ? p1_be_i    : p0_be_i;
        wdata_q    <= pick ? p1_wdata_i : p0_wdata_i;
        cnt        <= '0;
      end else if (state == ISSUE && !cap_en) begin
        cnt <= cnt + 1'b1;
      end
      if (cap_en) begin
        rdata_q <= cap_data;
        err_q   <= cap_err;
      end
    end
  end

  logic issue, done, busy;
  assign issue = (state == ISSUE);
  assign done  = (state == DONE);
  assign busy  = (state != IDLE);

  assign p0_gnt_o    = busy & ~owner;
  assign p1_gnt_o    = busy & owner;
  assign mem_req_o   = issue;
  assign mem_addr_o  = issue ? addr_q  : '0;
  assign mem_we_o    = issue & we_q;
  assign mem_be_o    = issue ? be_q    : '0;
  assign mem_wdata_o = issue ? wdata_q : '0;

  assign p0_rvalid_o = done & ~owner;
  assign p0_err_o    = done & ~owner & err_q;
  assign p0_rdata_o  = (done & ~owner) ? rdata_q : '0;
  assign p1_rvalid_o = done & owner;
  assign p1_err_o    = done & owner & err_q;
  assign p1_rdata_o  = (done & owner) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle table for the handshake and
// round-robin flow, then hand sequences for timeout, input stability and reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req_i, p1_req_i, p0_we_i, p1_we_i;
  logic [31:0] p0_addr_i, p1_addr_i, p0_wdata_i, p1_wdata_i;
  logic [3:0]  p0_be_i, p1_be_i;
  logic        p0_gnt_o, p0_rvalid_o, p0_err_o, p1_gnt_o, p1_rvalid_o, p1_err_o;
  logic [31:0] p0_rdata_o, p1_rdata_o;
  logic        mem_req_o, mem_we_o, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0]  BE0 = 4'hF;
  localparam logic [3:0]  BE1 = 4'h3;
  localparam logic [31:0] WD0 = 32'hAAAA_0000;
  localparam logic [31:0] WD1 = 32'h0000_5555;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .p0_req_i(p0_req_i), .p0_addr_i(p0_addr_i), .p0_we_i(p0_we_i), .p0_be_i(p0_be_i),
    .p0_wdata_i(p0_wdata_i), .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o),
    .p0_err_o(p0_err_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_addr_i(p1_addr_i), .p1_we_i(p1_we_i), .p1_be_i(p1_be_i),
    .p1_wdata_i(p1_wdata_i), .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o),
    .p1_err_o(p1_err_o), .p1_rdata_o(p1_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // ctl packs {p0_gnt, p1_gnt, mem_req, p0_rvalid, p0_err, p1_rvalid, p1_err}.
  typedef struct {
    logic        rb;
    logic        r0, r1;
    logic [31:0] a0, a1;
    logic        w0, w1;
    logic        mrv, merr;
    logic [31:0] mrd;
    logic [6:0]  ctl;
    logic [31:0] maddr;
    logic        mwe;
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rb, logic r0, logic r1, logic [31:0] a0, logic [31:0] a1,
                              logic w0, logic w1, logic mrv, logic merr, logic [31:0] mrd,
                              logic [6:0] ctl, logic [31:0] maddr, logic mwe,
                              logic [31:0] rd0, logic [31:0] rd1);
    vec_t v;
    v.rb = rb; v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1; v.w0 = w0; v.w1 = w1;
    v.mrv = mrv; v.merr = merr; v.mrd = mrd; v.ctl = ctl; v.maddr = maddr;
    v.mwe = mwe; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  function automatic logic [6:0] ctl_now();
    return {p0_gnt_o, p1_gnt_o, mem_req_o, p0_rvalid_o, p0_err_o, p1_rvalid_o, p1_err_o};
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {ctl_now(), mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, p0_rdata_o, p1_rdata_o},
          160'd0);
  endtask

  task automatic clear_inputs();
    p0_req_i = 0; p1_req_i = 0; p0_we_i = 0; p1_we_i = 0;
    p0_addr_i = 0; p1_addr_i = 0;
    p0_be_i = BE0; p1_be_i = BE1; p0_wdata_i = WD0; p1_wdata_i = WD1;
    mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_output(input vec_t v, input int idx);
    check($sformatf("vec%0d ctl", idx), 160'(ctl_now()), 160'(v.ctl));
    check($sformatf("vec%0d rdata", idx), {p0_rdata_o, p1_rdata_o}, {v.rd0, v.rd1});
    if (v.ctl[4])
      check($sformatf("vec%0d membus", idx), {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o},
            {v.maddr, v.mwe, v.ctl[6] ? BE0 : BE1, v.ctl[6] ? WD0 : WD1});
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    if (v.rb) reset_dut();
    @(negedge clk);
    p0_req_i = v.r0; p1_req_i = v.r1; p0_addr_i = v.a0; p1_addr_i = v.a1;
    p0_we_i = v.w0; p1_we_i = v.w1;
    mem_rvalid_i = v.mrv; mem_err_i = v.merr; mem_rdata_i = v.mrd;
    @(posedge clk);
    #1;
    check_output(v, idx);
  endtask

  initial begin
    // p0 read of 0x1000, completion three cycles after mem_req rises
    vecs.push_back(mk(0, 1, 0, 32'h1000, 0, 0, 0, 0, 0, 0,            7'b1010000, 32'h1000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h1000, 0, 0, 0, 0, 0, 0,            7'b1010000, 32'h1000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h1000, 0, 0, 0, 0, 0, 0,            7'b1010000, 32'h1000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 32'h1000, 0, 0, 0, 1, 0, 32'hDEADBEEF, 7'b1001000, 0, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(0, 0, 0, 32'h1000, 0, 0, 0, 0, 0, 0,            7'b0000000, 0, 0, 0, 0));
    // both ports requesting continuously, one-cycle completions: strict alternation
    vecs.push_back(mk(1, 1, 1, 32'h2000, 32'h0105, 0, 0, 0, 0, 0,            7'b1010000, 32'h2000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h2000, 32'h0105, 0, 0, 1, 0, 32'h11111111, 7'b1001000, 0, 0, 32'h11111111, 0));
    vecs.push_back(mk(0, 1, 1, 32'h2000, 32'h0105, 0, 0, 0, 0, 0,            7'b0000000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h2000, 32'h0105, 0, 0, 0, 0, 0,            7'b0110000, 32'h0105, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h2000, 32'h0105, 0, 0, 1, 0, 32'h22222222, 7'b0100010, 0, 0, 0, 32'h22222222));
    vecs.push_back(mk(0, 1, 1, 32'h2000, 32'h0105, 0, 0, 0, 0, 0,            7'b0000000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h2000, 32'h0105, 0, 0, 0, 0, 0,            7'b1010000, 32'h2000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h2000, 32'h0105, 0, 0, 1, 0, 32'h33333333, 7'b1001000, 0, 0, 32'h33333333, 0));
    vecs.push_back(mk(0, 1, 1, 32'h2000, 32'h0105, 0, 0, 0, 0, 0,            7'b0000000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h2000, 32'h0105, 0, 0, 0, 0, 0,            7'b0110000, 32'h0105, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h2000, 32'h0105, 0, 0, 1, 0, 32'h44444444, 7'b0100010, 0, 0, 0, 32'h44444444));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                          7'b0000000, 0, 0, 0, 0));
    // p1 write to a reserved address, mmu answers with error only
    vecs.push_back(mk(0, 0, 1, 0, 32'h0050, 0, 1, 0, 0, 0, 7'b0110000, 32'h0050, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0050, 0, 1, 0, 1, 0, 7'b0100011, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0050, 0, 1, 0, 0, 0, 7'b0000000, 0, 0, 0, 0));

    rst = 1'b0;
    clear_inputs();
    #1;
    check_all_zero("reset outputs");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i], i);

    // Watchdog: mem never answers; requester drops req after grant
    @(negedge clk);
    p0_req_i = 1; p0_addr_i = 32'h3000; p0_we_i = 0;
    @(posedge clk); #1;
    check("timeout grant", 160'(ctl_now()), 160'(7'b1010000));
    @(negedge clk);
    p0_req_i = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("timeout wait%0d", k), 160'(ctl_now()), 160'(7'b1010000));
    end
    @(posedge clk); #1;
    check("timeout done", {ctl_now(), p0_rdata_o}, {7'b1001100, 32'h0});
    @(posedge clk); #1;
    check("timeout after", 160'(ctl_now()), 160'(7'b0000000));

    // Requester inputs changing after grant must not reach the mem port
    @(negedge clk);
    p0_req_i = 1; p0_addr_i = 32'h1004; p0_we_i = 1;
    @(posedge clk); #1;
    check("hold grant", {ctl_now(), mem_addr_o, mem_we_o}, {7'b1010000, 32'h1004, 1'b1});
    @(negedge clk);
    p0_addr_i = 32'h1FFF; p0_we_i = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold addr%0d", k), {mem_req_o, mem_addr_o, mem_we_o}, {1'b1, 32'h1004, 1'b1});
    end
    @(negedge clk);
    mem_rvalid_i = 1; mem_rdata_i = 32'h0;
    @(posedge clk); #1;
    check("hold done", 160'(ctl_now()), 160'(7'b1001000));
    @(negedge clk);
    mem_rvalid_i = 0; p0_req_i = 0;
    @(posedge clk); #1;
    check("hold idle", 160'(ctl_now()), 160'(7'b0000000));

    // Reset during ISSUE: p0 owns the port so last_grant=0 before reset
    @(negedge clk);
    p0_req_i = 1; p0_addr_i = 32'h0200;
    @(posedge clk); #1;
    check("rst grant", 160'(ctl_now()), 160'(7'b1010000));
    @(negedge clk);
    rst = 1'b0; p0_req_i = 0;
    #1;
    check_all_zero("rst mid issue");
    @(negedge clk);
    mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0BAD0;
    @(negedge clk);
    mem_rvalid_i = 0; mem_rdata_i = 0; rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("rst quiet%0d", k), {ctl_now(), p0_rdata_o}, {7'b0000000, 32'h0});
    end
    @(negedge clk);
    p0_req_i = 1; p1_req_i = 1; p1_addr_i = 32'h0300;
    @(posedge clk); #1;
    check("rst tie to p0", {ctl_now(), mem_addr_o}, {7'b1010000, 32'h0200});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
